// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with a per-register busy scoreboard.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_2r1w #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 16,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                            I_CLK,
    input  logic                            I_NRESET,
    input  logic                            I_WR_EN,
    input  logic [ADDR_WIDTH-1:0]           I_WR_ADDR,
    input  logic [DATA_WIDTH-1:0]           I_WR_DATA,
    input  logic [ADDR_WIDTH-1:0]           I_RD_ADDR_A,
    input  logic [ADDR_WIDTH-1:0]           I_RD_ADDR_B,
    output logic [DATA_WIDTH-1:0]           O_RD_DATA_A,
    output logic [DATA_WIDTH-1:0]           O_RD_DATA_B,
    input  logic                            I_LOCK_EN,
    input  logic [ADDR_WIDTH-1:0]           I_LOCK_ADDR,
    output logic                            O_BUSY_A,
    output logic                            O_BUSY_B,
    output logic [REG_COUNT*DATA_WIDTH-1:0] O_REG_DATA
);

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
    logic [REG_COUNT-1:0]  busy_q;
    logic [REG_COUNT-1:0]  busy_d;

    // Address decode by comparison, so out-of-range addresses match nothing.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int k = 0; k < REG_COUNT; k++) begin
            if (I_WR_EN && I_WR_ADDR == ADDR_WIDTH'(k)) begin
                regs_d[k] = I_WR_DATA;
                busy_d[k] = 1'b0;
            end
            if (I_LOCK_EN && I_LOCK_ADDR == ADDR_WIDTH'(k)) begin
                busy_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_NRESET) begin
            busy_q <= '0;
            for (int k = 0; k < REG_COUNT; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int k = 0; k < REG_COUNT; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    always_comb begin
        O_RD_DATA_A = '0;
        O_RD_DATA_B = '0;
        O_BUSY_A    = 1'b0;
        O_BUSY_B    = 1'b0;
        for (int k = 0; k < REG_COUNT; k++) begin
            if (I_RD_ADDR_A == ADDR_WIDTH'(k)) begin
                O_RD_DATA_A = regs_q[k];
                O_BUSY_A    = busy_q[k];
            end
            if (I_RD_ADDR_B == ADDR_WIDTH'(k)) begin
                O_RD_DATA_B = regs_q[k];
                O_BUSY_B    = busy_q[k];
            end
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (I_WR_EN && int'(I_WR_ADDR) < REG_COUNT) begin
            if (I_WR_ADDR == I_RD_ADDR_A) begin
                O_RD_DATA_A = I_WR_DATA;
                O_BUSY_A    = I_LOCK_EN && (I_LOCK_ADDR == I_RD_ADDR_A);
            end
            if (I_WR_ADDR == I_RD_ADDR_B) begin
                O_RD_DATA_B = I_WR_DATA;
                O_BUSY_B    = I_LOCK_EN && (I_LOCK_ADDR == I_RD_ADDR_B);
            end
        end
`endif
    end

    // The debug dump always shows stored state, never forwarded data.
    for (genvar g = 0; g < REG_COUNT; g++) begin : g_dump
        assign O_REG_DATA[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: a 16x16 instance and a 12x8 instance share stimulus
// and are compared every cycle against array models of the register file.
module tb_regfile_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst, wr_en, lock_en;
    logic [3:0]  wr_addr, lock_addr, ra, rb;
    logic [15:0] wr_data;

    logic [15:0]  rda1, rdb1;
    logic         bsa1, bsb1;
    logic [255:0] dump1;
    logic [7:0]   rda2, rdb2;
    logic         bsa2, bsb2;
    logic [95:0]  dump2;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    logic [15:0] m1 [16];
    bit          bz1[16];
    logic [7:0]  m2 [12];
    bit          bz2[12];

    regfile_2r1w u_dut16 (
        .I_CLK(clk), .I_NRESET(nrst),
        .I_WR_EN(wr_en), .I_WR_ADDR(wr_addr), .I_WR_DATA(wr_data),
        .I_RD_ADDR_A(ra), .I_RD_ADDR_B(rb),
        .O_RD_DATA_A(rda1), .O_RD_DATA_B(rdb1),
        .I_LOCK_EN(lock_en), .I_LOCK_ADDR(lock_addr),
        .O_BUSY_A(bsa1), .O_BUSY_B(bsb1), .O_REG_DATA(dump1)
    );

    regfile_2r1w #(.DATA_WIDTH(8), .REG_COUNT(12)) u_dut12 (
        .I_CLK(clk), .I_NRESET(nrst),
        .I_WR_EN(wr_en), .I_WR_ADDR(wr_addr), .I_WR_DATA(wr_data[7:0]),
        .I_RD_ADDR_A(ra), .I_RD_ADDR_B(rb),
        .O_RD_DATA_A(rda2), .O_RD_DATA_B(rdb2),
        .I_LOCK_EN(lock_en), .I_LOCK_ADDR(lock_addr),
        .O_BUSY_A(bsa2), .O_BUSY_B(bsb2), .O_REG_DATA(dump2)
    );

    task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Reference model: state changes at the rising edge.
    always @(posedge clk) begin
        int wa, la;
        wa = int'(wr_addr);
        la = int'(lock_addr);
        if (!nrst) begin
            for (int k = 0; k < 16; k++) begin m1[k] = '0; bz1[k] = 1'b0; end
            for (int k = 0; k < 12; k++) begin m2[k] = '0; bz2[k] = 1'b0; end
        end else begin
            if (wr_en) begin
                m1[wa] = wr_data;
                bz1[wa] = 1'b0;
                if (wa < 12) begin m2[wa] = wr_data[7:0]; bz2[wa] = 1'b0; end
            end
            if (lock_en) begin
                bz1[la] = 1'b1;
                if (la < 12) bz2[la] = 1'b1;
            end
        end
    end

    function automatic logic [15:0] exp_rd1(input logic [3:0] a);
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m1[int'(a)];
    endfunction

    function automatic logic exp_bs1(input logic [3:0] a);
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_en && wr_addr == a) return lock_en && lock_addr == a;
`endif
        return bz1[int'(a)];
    endfunction

    function automatic logic [7:0] exp_rd2(input logic [3:0] a);
        if (int'(a) >= 12) return 8'h00;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data[7:0];
`endif
        return m2[int'(a)];
    endfunction

    function automatic logic exp_bs2(input logic [3:0] a);
        if (int'(a) >= 12) return 1'b0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_en && wr_addr == a) return lock_en && lock_addr == a;
`endif
        return bz2[int'(a)];
    endfunction

    always @(negedge clk) begin : cmp
        logic [255:0] e1;
        logic [95:0]  e2;
        if (run_cmp) begin
            for (int k = 0; k < 16; k++) e1[k*16 +: 16] = m1[k];
            for (int k = 0; k < 12; k++) e2[k*8 +: 8] = m2[k];
            chk("m16_rd_a", rda1, exp_rd1(ra));
            chk("m16_rd_b", rdb1, exp_rd1(rb));
            chk("m16_busy_a", bsa1, exp_bs1(ra));
            chk("m16_busy_b", bsb1, exp_bs1(rb));
            chk("m16_dump", dump1, e1);
            chk("m12_rd_a", rda2, exp_rd2(ra));
            chk("m12_rd_b", rdb2, exp_rd2(rb));
            chk("m12_busy_a", bsa2, exp_bs2(ra));
            chk("m12_busy_b", bsb2, exp_bs2(rb));
            chk("m12_dump", dump2, e2);
        end
    end

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    initial begin
        logic [95:0] lit2;
        nrst = 1'b0; wr_en = 1'b0; lock_en = 1'b0;
        wr_addr = '0; lock_addr = '0; ra = '0; rb = '0; wr_data = '0;
        clk_edge();
        run_cmp = 1'b1;
        half();
        chk("rst_dump16", dump1, 256'h0);
        chk("rst_dump12", dump2, 96'h0);
        chk("rst_rd_a", rda1, 16'h0);
        chk("rst_busy_a", bsa1, 1'b0);

        // Reset after prior writes and locks.
        nrst = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h4444;
        lock_en = 1'b1; lock_addr = 4'd9;
        clk_edge();
        wr_en = 1'b0; lock_en = 1'b0; ra = 4'd4; rb = 4'd9;
        half();
        chk("pre_rst_rd", rda1, 16'h4444);
        chk("pre_rst_busy", bsb1, 1'b1);
        nrst = 1'b0;
        clk_edge();
        clk_edge();
        nrst = 1'b1;
        half();
        chk("rst2_dump16", dump1, 256'h0);
        chk("rst2_rd_a", rda1, 16'h0);
        chk("rst2_busy_b", bsb1, 1'b0);

        // Write/readback sweep.
        for (int k = 0; k < 16; k++) begin
            wr_en = 1'b1; wr_addr = 4'(k); wr_data = 16'h1000 + 16'(k);
            clk_edge();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ra = 4'(k); rb = 4'(15 - k);
            half();
            chk("sweep_a", rda1, 16'h1000 + 16'(k));
            chk("sweep_b", rdb1, 16'h100F - 16'(k));
        end

        // Scoreboard.
        lock_en = 1'b1; lock_addr = 4'd5;
        clk_edge();
        lock_en = 1'b0; ra = 4'd5;
        half();
        chk("lock_busy", bsa1, 1'b1);
        clk_edge();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
        clk_edge();
        wr_en = 1'b0;
        half();
        chk("retire_busy", bsa1, 1'b0);
        chk("retire_data", rda1, 16'hBEEF);
        clk_edge();
        wr_en = 1'b1; lock_en = 1'b1; wr_addr = 4'd5; lock_addr = 4'd5;
        wr_data = 16'h5555;
        clk_edge();
        wr_en = 1'b0; lock_en = 1'b0;
        half();
        chk("relock_busy", bsa1, 1'b1);
        chk("relock_data", rda1, 16'h5555);
        clk_edge();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h7777;
        lock_en = 1'b1; lock_addr = 4'd6;
        clk_edge();
        wr_en = 1'b0; lock_en = 1'b0; ra = 4'd7; rb = 4'd6;
        half();
        chk("indep_data", rda1, 16'h7777);
        chk("indep_busy_w", bsa1, 1'b0);
        chk("indep_busy_l", bsb1, 1'b1);

        // Forwarding behaviour.
        clk_edge();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h00AA; ra = 4'd3;
        half();
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("bypass_pre", rda1, 16'h00AA);
`else
        chk("bypass_pre", rda1, 16'h1003);
`endif
        clk_edge();
        wr_en = 1'b0;
        half();
        chk("bypass_post", rda1, 16'h00AA);

        // Out-of-range access on the 12-entry instance.
        clk_edge();
        wr_en = 1'b1; wr_addr = 4'd13; wr_data = 16'h00FF;
        lock_en = 1'b1; lock_addr = 4'd13;
        clk_edge();
        wr_en = 1'b0; lock_en = 1'b0; ra = 4'd13;
        half();
        chk("oor_rd", rda2, 8'h00);
        chk("oor_busy", bsa2, 1'b0);
        chk("oor_in16", rda1, 16'h00FF);
        for (int k = 0; k < 12; k++) begin
            lit2[k*8 +: 8] = 8'(k);
        end
        lit2[3*8 +: 8] = 8'hAA;
        lit2[5*8 +: 8] = 8'h55;
        lit2[7*8 +: 8] = 8'h77;
        chk("oor_dump", dump2, lit2);

        // Reset discards a same-cycle lock and write.
        clk_edge();
        lock_en = 1'b1; lock_addr = 4'd2;
        clk_edge();
        nrst = 1'b0; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h1234;
        clk_edge();
        nrst = 1'b1; wr_en = 1'b0; lock_en = 1'b0; ra = 4'd2;
        half();
        chk("midrst_rd", rda1, 16'h0);
        chk("midrst_busy", bsa1, 1'b0);
        chk("midrst_rd12", rda2, 8'h00);

        // Randomised traffic against the model.
        repeat (800) begin
            nrst      = ($urandom_range(0, 39) != 0);
            wr_en     = 1'($urandom_range(0, 1));
            lock_en   = 1'($urandom_range(0, 1));
            wr_addr   = 4'($urandom_range(0, 15));
            lock_addr = 4'($urandom_range(0, 15));
            ra        = 4'($urandom_range(0, 15));
            rb        = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            wr_data   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) lock_addr = wr_addr;
            clk_edge();
        end
        half();
        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
